// File: rtl/ysyx_22041412_axi_rd_pkg.sv
// Shared definitions for the AXI4 read-channel master: FSM states, burst/response codes
// and ARSIZE encodings.
package ysyx_22041412_axi_rd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DRAIN,
        ST_DONE
    } rd_state_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] BUST_1 = 3'd0;
    localparam logic [2:0] BUST_2 = 3'd1;
    localparam logic [2:0] BUST_4 = 3'd2;
    localparam logic [2:0] BUST_8 = 3'd3;

endpackage

// File: rtl/ysyx_22041412_axi_rd.sv
// AXI4 read master: one AR handshake plus an INCR R burst per arbiter request,
// with per-beat delivery pulses and silent draining of withdrawn requests.
module ysyx_22041412_axi_rd
    import ysyx_22041412_axi_rd_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      r_valid_i,
    input  logic [AXI_ADDR_WIDTH-1:0] r_addr_i,
    input  logic [2:0]                r_size_i,
    input  logic [7:0]                r_len_i,
    output logic                      r_ready_o,
    output logic [AXI_DATA_WIDTH-1:0] data_read_o,
    output logic                      r_last_i,
    output logic                      rd_err_o,
    input  logic                      axi_ar_ready_i,
    output logic                      axi_ar_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr_o,
    output logic [AXI_ID_WIDTH-1:0]   axi_ar_id_o,
    output logic [7:0]                axi_ar_len_o,
    output logic [2:0]                axi_ar_size_o,
    output logic [1:0]                axi_ar_burst_o,
    output logic                      axi_r_ready_o,
    input  logic                      axi_r_valid_i,
    input  logic [1:0]                axi_r_resp_i,
    input  logic [AXI_DATA_WIDTH-1:0] axi_r_data_i,
    input  logic                      axi_r_last_i
);

    rd_state_t                 state, state_next;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [2:0]                size_q;
    logic [7:0]                len_q;
    logic [7:0]                cnt_q;
    logic                      beat;
    logic                      final_beat;

    assign axi_ar_addr_o  = addr_q;
    assign axi_ar_len_o   = len_q;
    assign axi_ar_size_o  = size_q;
    assign axi_ar_id_o    = '0;
    assign axi_ar_burst_o = BURST_INCR;

    // Burst end comes from our own beat count; axi_r_last_i is only cross-checked.
    assign final_beat = (cnt_q == len_q);
    assign beat       = axi_r_valid_i && axi_r_ready_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        axi_ar_valid_o = 1'b0;
        axi_r_ready_o  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (r_valid_i) state_next = ST_ADDR;
            end
            ST_ADDR: begin
                axi_ar_valid_o = 1'b1;
                if (axi_ar_ready_i) state_next = r_valid_i ? ST_DATA : ST_DRAIN;
            end
            ST_DATA: begin
                axi_r_ready_o = 1'b1;
                if (axi_r_valid_i && final_beat) state_next = ST_DONE;
                else if (!r_valid_i)             state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                axi_r_ready_o = 1'b1;
                if (axi_r_valid_i && final_beat) state_next = ST_IDLE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q      <= '0;
            size_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            rd_err_o    <= 1'b0;
            r_ready_o   <= 1'b0;
            r_last_i    <= 1'b0;
            data_read_o <= '0;
        end else begin
            r_ready_o <= 1'b0;
            r_last_i  <= 1'b0;
            if (state == ST_IDLE && r_valid_i) begin
                addr_q   <= r_addr_i;
                size_q   <= r_size_i;
                len_q    <= r_len_i;
                cnt_q    <= '0;
                rd_err_o <= 1'b0;
            end
            if (beat) begin
                cnt_q <= cnt_q + 8'd1;
                if (axi_r_resp_i[1] || (axi_r_last_i != final_beat)) rd_err_o <= 1'b1;
                if (state == ST_DATA) begin
                    data_read_o <= axi_r_data_i;
                    r_ready_o   <= 1'b1;
                    r_last_i    <= final_beat;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22041412_axi_rd.sv
// Scoreboard bench for the AXI read master: stimulus pushes expected delivered beats,
// a negedge monitor pops and compares them whenever r_ready_o pulses.
module tb_ysyx_22041412_axi_rd;
    import ysyx_22041412_axi_rd_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        r_valid_i = 1'b0;
    logic [31:0] r_addr_i = '0;
    logic [2:0]  r_size_i = '0;
    logic [7:0]  r_len_i = '0;
    logic        r_ready_o;
    logic [63:0] data_read_o;
    logic        r_last_i;
    logic        rd_err_o;
    logic        axi_ar_ready_i = 1'b0;
    logic        axi_ar_valid_o;
    logic [31:0] axi_ar_addr_o;
    logic [3:0]  axi_ar_id_o;
    logic [7:0]  axi_ar_len_o;
    logic [2:0]  axi_ar_size_o;
    logic [1:0]  axi_ar_burst_o;
    logic        axi_r_ready_o;
    logic        axi_r_valid_i = 1'b0;
    logic [1:0]  axi_r_resp_i = '0;
    logic [63:0] axi_r_data_i = '0;
    logic        axi_r_last_i = 1'b0;

    ysyx_22041412_axi_rd #(
        .AXI_DATA_WIDTH(64),
        .AXI_ADDR_WIDTH(32),
        .AXI_ID_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .r_valid_i(r_valid_i), .r_addr_i(r_addr_i), .r_size_i(r_size_i), .r_len_i(r_len_i),
        .r_ready_o(r_ready_o), .data_read_o(data_read_o), .r_last_i(r_last_i), .rd_err_o(rd_err_o),
        .axi_ar_ready_i(axi_ar_ready_i), .axi_ar_valid_o(axi_ar_valid_o), .axi_ar_addr_o(axi_ar_addr_o),
        .axi_ar_id_o(axi_ar_id_o), .axi_ar_len_o(axi_ar_len_o), .axi_ar_size_o(axi_ar_size_o),
        .axi_ar_burst_o(axi_ar_burst_o), .axi_r_ready_o(axi_r_ready_o), .axi_r_valid_i(axi_r_valid_i),
        .axi_r_resp_i(axi_r_resp_i), .axi_r_data_i(axi_r_data_i), .axi_r_last_i(axi_r_last_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst && r_ready_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 64'(r_ready_o), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("beat_data", data_read_o, mon_e.data);
                chk("beat_last", 64'(r_last_i), 64'(mon_e.last));
            end
        end else if (rst && r_last_i) begin
            chk("last_without_ready", 64'(r_last_i), 64'd0);
        end
    end

    task automatic run_txn(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input int ar_wait, input bit gaps, input int drop_after,
                           input int err_beat, input int bad_last, input logic [63:0] base);
        r_valid_i = 1'b1;
        r_addr_i  = addr;
        r_len_i   = len;
        r_size_i  = size;
        @(posedge clk); #1;
        // Scramble request fields: AR must come from the latched copies.
        r_addr_i = ~addr;
        r_len_i  = ~len;
        r_size_i = ~size;
        chk("err_cleared", 64'(rd_err_o), 64'd0);
        for (int w = 0; w <= ar_wait; w++) begin
            axi_ar_ready_i = (w == ar_wait);
            chk("ar_valid", 64'(axi_ar_valid_o), 64'd1);
            chk("ar_addr", 64'(axi_ar_addr_o), 64'(addr));
            chk("ar_len", 64'(axi_ar_len_o), 64'(len));
            chk("ar_size", 64'(axi_ar_size_o), 64'(size));
            chk("axi_r_ready_in_addr", 64'(axi_r_ready_o), 64'd0);
            @(posedge clk); #1;
        end
        axi_ar_ready_i = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            if (gaps && b > 0) begin
                axi_r_valid_i = 1'b0;
                @(posedge clk); #1;
            end
            chk("axi_r_ready", 64'(axi_r_ready_o), 64'd1);
            chk("ar_valid_off", 64'(axi_ar_valid_o), 64'd0);
            axi_r_valid_i = 1'b1;
            axi_r_data_i  = base + 64'(b);
            axi_r_last_i  = (b == int'(len)) ^ (b == bad_last);
            axi_r_resp_i  = (b == err_beat) ? RESP_SLVERR : RESP_OKAY;
            if (drop_after < 0 || b <= drop_after)
                exp_q.push_back({base + 64'(b), (b == int'(len))});
            @(posedge clk); #1;
            if (b == drop_after || b == int'(len)) r_valid_i = 1'b0;
            if (b == err_beat) chk("err_on_slverr", 64'(rd_err_o), 64'd1);
        end
        axi_r_valid_i = 1'b0;
        axi_r_last_i  = 1'b0;
        axi_r_resp_i  = RESP_OKAY;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("idle_ar_valid", 64'(axi_ar_valid_o), 64'd0);
        chk("idle_axi_r_ready", 64'(axi_r_ready_o), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        #1;
        chk("rst_r_ready", 64'(r_ready_o), 64'd0);
        chk("rst_ar_valid", 64'(axi_ar_valid_o), 64'd0);
        chk("rst_axi_r_ready", 64'(axi_r_ready_o), 64'd0);
        chk("rst_rd_err", 64'(rd_err_o), 64'd0);
        chk("rst_burst", 64'(axi_ar_burst_o), 64'(BURST_INCR));
        chk("rst_ar_id", 64'(axi_ar_id_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Single beat, zero-wait AR.
        run_txn(32'h8000_0000, 8'd0, BUST_8, 0, 1'b0, -1, -1, -1, 64'hDEAD_BEEF_0123_4567);
        chk("t1_err", 64'(rd_err_o), 64'd0);

        // Eight beats, AR ready late, R valid every other cycle.
        run_txn(32'h8000_1000, 8'd7, BUST_8, 3, 1'b1, -1, -1, -1, 64'hA5A5_0000_0000_0010);
        chk("t2_err", 64'(rd_err_o), 64'd0);

        // Request withdrawn after beat 1: beats 2..3 drained silently, no new AR.
        run_txn(32'h8000_2000, 8'd3, BUST_4, 0, 1'b1, 1, -1, -1, 64'h0BAD_0000_0000_0020);
        repeat (3) begin
            @(posedge clk); #1;
            chk("drain_no_new_ar", 64'(axi_ar_valid_o), 64'd0);
        end

        // SLVERR on first beat: error sticky until the next acceptance.
        run_txn(32'h8000_3000, 8'd1, BUST_8, 1, 1'b0, -1, 0, -1, 64'hC0DE_0000_0000_0030);
        repeat (2) @(posedge clk);
        #1 chk("err_sticky", 64'(rd_err_o), 64'd1);

        // axi_r_last_i on beat 2 of 4: error, but r_last_i still only on beat 4.
        run_txn(32'h8000_4000, 8'd3, BUST_2, 0, 1'b0, -1, -1, 1, 64'hFACE_0000_0000_0040);
        chk("t5_err", 64'(rd_err_o), 64'd1);

        // Asynchronous reset in the middle of a burst.
        r_valid_i = 1'b1; r_addr_i = 32'h8000_5000; r_len_i = 8'd3; r_size_i = BUST_8;
        @(posedge clk); #1;
        axi_ar_ready_i = 1'b1;
        @(posedge clk); #1;
        axi_ar_ready_i = 1'b0;
        axi_r_valid_i = 1'b1; axi_r_data_i = 64'h1234_5678_9ABC_DEF0; axi_r_last_i = 1'b0;
        exp_q.push_back({64'h1234_5678_9ABC_DEF0, 1'b0});
        @(posedge clk); #1;
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_r_ready", 64'(r_ready_o), 64'd0);
        chk("mid_rst_data", data_read_o, 64'd0);
        chk("mid_rst_ar_valid", 64'(axi_ar_valid_o), 64'd0);
        chk("mid_rst_axi_r_ready", 64'(axi_r_ready_o), 64'd0);
        chk("mid_rst_ar_addr", 64'(axi_ar_addr_o), 64'd0);
        chk("mid_rst_ar_len", 64'(axi_ar_len_o), 64'd0);
        chk("mid_rst_burst", 64'(axi_ar_burst_o), 64'(BURST_INCR));
        axi_r_valid_i = 1'b0;
        r_valid_i = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", 64'(axi_ar_valid_o), 64'd0);

        run_txn(32'h8000_6000, 8'd2, BUST_8, 0, 1'b0, -1, -1, -1, 64'h7777_0000_0000_0060);
        chk("final_err", 64'(rd_err_o), 64'd0);

        repeat (2) @(posedge clk);
        #1 chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
